router_reg: RTL and testbench

- Datapath register stage of the 1x3 router. It sits between the input byte stream and the three output FIFOs, alongside the router FSM.
- Driven by the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Latches the header, forwards header and payload bytes to the FIFO write bus, and holds a byte that arrives while the FIFO is full.
- Accumulates XOR parity, captures the packet parity byte, and produces parity_done, low_pkt_valid and err back to the FSM and top level.

---
 rtl/router_reg_if.sv | 32 +++
 rtl/router_reg.sv | 150 +++++++++++++++
 tb/tb_router_reg.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/router_reg_if.sv
// Byte/strobe bus between the router FSM side and the datapath register stage.
interface router_reg_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data_in;
   logic                  pkt_valid;
   logic                  fifo_full;
   logic                  detect_add;
   logic                  lfd_state;
   logic                  ld_state;
   logic                  laf_state;
   logic                  full_state;
   logic                  rst_int_reg;
   logic                  parity_done;
   logic                  low_pkt_valid;
   logic                  err;
   logic [DATA_WIDTH-1:0] dout;

   // Source side: drives the byte stream and FSM strobes, observes status.
   modport master (
      output data_in, pkt_valid, fifo_full,
      output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
      input  parity_done, low_pkt_valid, err, dout
   );

   // Register stage side.
   modport slave (
      input  data_in, pkt_valid, fifo_full,
      input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
      output parity_done, low_pkt_valid, err, dout
   );
endinterface

// File: rtl/router_reg.sv
// Datapath register stage of the 1x3 router: header latch, FIFO write byte,
// full-time hold byte, running XOR parity and parity-error reporting.
module router_reg #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 2
) (
   input  logic        clock,
   input  logic        reset,
   router_reg_if.slave bus
);

   // Running parity accumulation step.
   function automatic logic [DATA_WIDTH-1:0] par_acc(input logic [DATA_WIDTH-1:0] acc,
                                                     input logic [DATA_WIDTH-1:0] b);
      par_acc = acc ^ b;
   endfunction

   // High when the received parity byte disagrees with the accumulated parity.
   function automatic logic par_mismatch(input logic [DATA_WIDTH-1:0] rx,
                                         input logic [DATA_WIDTH-1:0] acc);
      par_mismatch = |(rx ^ acc);
   endfunction

   logic [DATA_WIDTH-1:0] header_q, header_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  hold_is_par_q, hold_is_par_d;
   logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
   logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
   logic                  cmp_pend_q, cmp_pend_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  parity_done_q, parity_done_d;
   logic                  low_pkt_valid_q, low_pkt_valid_d;
   logic                  err_q, err_d;
   logic                  addr_ok_s;

   assign addr_ok_s = (bus.data_in[ADDR_BITS-1:0] != {ADDR_BITS{1'b1}});

   // Next-state for every datapath register, driven by the one active FSM strobe.
   always_comb begin
      header_d        = header_q;
      hold_d          = hold_q;
      hold_is_par_d   = hold_is_par_q;
      int_par_d       = int_par_q;
      pkt_par_d       = pkt_par_q;
      cmp_pend_d      = cmp_pend_q;
      dout_d          = dout_q;
      parity_done_d   = parity_done_q;
      low_pkt_valid_d = low_pkt_valid_q;
      err_d           = err_q;

      // Compare one cycle after the parity byte lands so both operands are settled.
      if (cmp_pend_q) begin
         err_d      = par_mismatch(pkt_par_q, int_par_q);
         cmp_pend_d = 1'b0;
      end else begin
         cmp_pend_d = cmp_pend_q;
      end

      if (bus.detect_add) begin
         parity_done_d = 1'b0;
         err_d         = 1'b0;
         if (bus.pkt_valid && addr_ok_s) begin
            header_d   = bus.data_in;
            int_par_d  = {DATA_WIDTH{1'b0}};
            cmp_pend_d = 1'b0;
         end else begin
            header_d = header_q;
         end
      end else if (bus.lfd_state) begin
         dout_d    = header_q;
         int_par_d = par_acc(int_par_q, header_q);
      end else if (bus.ld_state) begin
         if (bus.fifo_full) begin
            // Park the byte; it is replayed from LOAD_AFTER_FULL.
            hold_d        = bus.data_in;
            hold_is_par_d = !bus.pkt_valid;
         end else if (bus.pkt_valid) begin
            dout_d    = bus.data_in;
            int_par_d = par_acc(int_par_q, bus.data_in);
         end else begin
            dout_d        = bus.data_in;
            pkt_par_d     = bus.data_in;
            parity_done_d = 1'b1;
         end
      end else if (bus.laf_state) begin
         if (!parity_done_q) begin
            dout_d = hold_q;
            if (hold_is_par_q) begin
               pkt_par_d     = hold_q;
               parity_done_d = 1'b1;
            end else begin
               int_par_d = par_acc(int_par_q, hold_q);
            end
         end else begin
            dout_d = dout_q;
         end
      end else begin
         // FIFO_FULL_STATE, CHECK_PARITY_ERROR and idle leave the datapath alone.
         dout_d = dout_q;
      end

      if (!parity_done_q && parity_done_d) begin
         cmp_pend_d = 1'b1;
      end else begin
         cmp_pend_d = cmp_pend_d;
      end

      // Clear has priority over a simultaneous set.
      if (bus.rst_int_reg) begin
         low_pkt_valid_d = 1'b0;
      end else if (bus.ld_state && !bus.pkt_valid) begin
         low_pkt_valid_d = 1'b1;
      end else begin
         low_pkt_valid_d = low_pkt_valid_q;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         header_q        <= {DATA_WIDTH{1'b0}};
         hold_q          <= {DATA_WIDTH{1'b0}};
         hold_is_par_q   <= 1'b0;
         int_par_q       <= {DATA_WIDTH{1'b0}};
         pkt_par_q       <= {DATA_WIDTH{1'b0}};
         cmp_pend_q      <= 1'b0;
         dout_q          <= {DATA_WIDTH{1'b0}};
         parity_done_q   <= 1'b0;
         low_pkt_valid_q <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         header_q        <= header_d;
         hold_q          <= hold_d;
         hold_is_par_q   <= hold_is_par_d;
         int_par_q       <= int_par_d;
         pkt_par_q       <= pkt_par_d;
         cmp_pend_q      <= cmp_pend_d;
         dout_q          <= dout_d;
         parity_done_q   <= parity_done_d;
         low_pkt_valid_q <= low_pkt_valid_d;
         err_q           <= err_d;
      end
   end

   assign bus.dout          = dout_q;
   assign bus.parity_done   = parity_done_q;
   assign bus.low_pkt_valid = low_pkt_valid_q;
   assign bus.err           = err_q;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: FSM strobe sequences with hand-computed results.
module tb_router_reg;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   router_reg_if #(.DATA_WIDTH(8)) bus ();

   router_reg #(.DATA_WIDTH(8), .ADDR_BITS(2)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one FSM cycle, then sample 1 time unit after the edge.
   task automatic cyc(input logic da, input logic lfd, input logic ld, input logic laf,
                      input logic ffs, input logic rir, input logic [7:0] d,
                      input logic pv, input logic full);
      bus.detect_add  = da;
      bus.lfd_state   = lfd;
      bus.ld_state    = ld;
      bus.laf_state   = laf;
      bus.full_state  = ffs;
      bus.rst_int_reg = rir;
      bus.data_in     = d;
      bus.pkt_valid   = pv;
      bus.fifo_full   = full;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL rst_dout: got %h want %h", bus.dout, 8'h00); end
      checks++; if (bus.parity_done !== 1'b0) begin errors++; $display("FAIL rst_pdone: got %b want 0", bus.parity_done); end
      checks++; if (bus.low_pkt_valid !== 1'b0) begin errors++; $display("FAIL rst_lpv: got %b want 0", bus.low_pkt_valid); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
      reset = 1'b0;
   endtask

   task automatic test_good_packet;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0);
      checks++; if (bus.parity_done !== 1'b0) begin errors++; $display("FAIL good_da_pdone: got %b want 0", bus.parity_done); end
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0);
      checks++; if (bus.dout !== 8'h05) begin errors++; $display("FAIL good_lfd_dout: got %h want %h", bus.dout, 8'h05); end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0);
      checks++; if (bus.dout !== 8'hA3) begin errors++; $display("FAIL good_ld_dout: got %h want %h", bus.dout, 8'hA3); end
      checks++; if (bus.low_pkt_valid !== 1'b0) begin errors++; $display("FAIL good_ld_lpv: got %b want 0", bus.low_pkt_valid); end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA6, 1'b0, 1'b0);
      checks++; if (bus.dout !== 8'hA6) begin errors++; $display("FAIL good_par_dout: got %h want %h", bus.dout, 8'hA6); end
      checks++; if (bus.parity_done !== 1'b1) begin errors++; $display("FAIL good_par_pdone: got %b want 1", bus.parity_done); end
      checks++; if (bus.low_pkt_valid !== 1'b1) begin errors++; $display("FAIL good_par_lpv: got %b want 1", bus.low_pkt_valid); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.low_pkt_valid !== 1'b0) begin errors++; $display("FAIL good_cpe_lpv: got %b want 0", bus.low_pkt_valid); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL good_cpe_err: got %b want 0", bus.err); end
      checks++; if (bus.parity_done !== 1'b1) begin errors++; $display("FAIL good_cpe_pdone: got %b want 1", bus.parity_done); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL good_idle_err: got %b want 0", bus.err); end
   endtask

   task automatic test_bad_parity;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA7, 1'b0, 1'b0);
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL bad_err_early: got %b want 0", bus.err); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL bad_err: got %b want 1", bus.err); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL bad_err_hold: got %b want 1", bus.err); end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h09, 1'b1, 1'b0);
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL bad_err_clear: got %b want 0", bus.err); end
      checks++; if (bus.parity_done !== 1'b0) begin errors++; $display("FAIL bad_pdone_clear: got %b want 0", bus.parity_done); end
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (bus.dout !== 8'h09) begin errors++; $display("FAIL bad_next_hdr: got %h want %h", bus.dout, 8'h09); end
   endtask

   task automatic test_full_payload;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h06, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0);
      checks++; if (bus.dout !== 8'h06) begin errors++; $display("FAIL fp_lfd_dout: got %h want %h", bus.dout, 8'h06); end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1);
      checks++; if (bus.dout !== 8'h06) begin errors++; $display("FAIL fp_full_dout: got %h want %h", bus.dout, 8'h06); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b1);
      checks++; if (bus.dout !== 8'h06) begin errors++; $display("FAIL fp_ffs_dout: got %h want %h", bus.dout, 8'h06); end
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0);
      checks++; if (bus.dout !== 8'h11) begin errors++; $display("FAIL fp_laf_dout: got %h want %h", bus.dout, 8'h11); end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0);
      checks++; if (bus.dout !== 8'h22) begin errors++; $display("FAIL fp_ld_dout: got %h want %h", bus.dout, 8'h22); end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0);
      checks++; if (bus.dout !== 8'h35) begin errors++; $display("FAIL fp_par_dout: got %h want %h", bus.dout, 8'h35); end
      checks++; if (bus.parity_done !== 1'b1) begin errors++; $display("FAIL fp_pdone: got %b want 1", bus.parity_done); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL fp_err: got %b want 0", bus.err); end
   endtask

   task automatic test_full_parity;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA6, 1'b0, 1'b1);
      checks++; if (bus.low_pkt_valid !== 1'b1) begin errors++; $display("FAIL fpar_lpv: got %b want 1", bus.low_pkt_valid); end
      checks++; if (bus.parity_done !== 1'b0) begin errors++; $display("FAIL fpar_pdone_ld: got %b want 0", bus.parity_done); end
      checks++; if (bus.dout !== 8'hA3) begin errors++; $display("FAIL fpar_ld_dout: got %h want %h", bus.dout, 8'hA3); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      checks++; if (bus.parity_done !== 1'b0) begin errors++; $display("FAIL fpar_pdone_ffs: got %b want 0", bus.parity_done); end
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
      checks++; if (bus.dout !== 8'hA6) begin errors++; $display("FAIL fpar_laf_dout: got %h want %h", bus.dout, 8'hA6); end
      checks++; if (bus.parity_done !== 1'b1) begin errors++; $display("FAIL fpar_laf_pdone: got %b want 1", bus.parity_done); end
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
      checks++; if (bus.dout !== 8'hA6) begin errors++; $display("FAIL fpar_laf2_dout: got %h want %h", bus.dout, 8'hA6); end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL fpar_err: got %b want 0", bus.err); end
      checks++; if (bus.low_pkt_valid !== 1'b0) begin errors++; $display("FAIL fpar_lpv_clr: got %b want 0", bus.low_pkt_valid); end
   endtask

   task automatic test_invalid_addr;
      // Header-only packet 0A with parity 00: int_par = 0A, so err must be set.
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0A, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL inv_pre_err: got %b want 1", bus.err); end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0);
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL inv_err: got %b want 0", bus.err); end
      checks++; if (bus.parity_done !== 1'b0) begin errors++; $display("FAIL inv_pdone: got %b want 0", bus.parity_done); end
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0);
      checks++; if (bus.dout !== 8'h0A) begin errors++; $display("FAIL inv_old_hdr: got %h want %h", bus.dout, 8'h0A); end
   endtask

   task automatic test_reset_mid_payload;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b1, 1'b0);
      checks++; if (bus.dout !== 8'hA3) begin errors++; $display("FAIL mrst_pre_dout: got %h want %h", bus.dout, 8'hA3); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (bus.dout !== 8'h00) begin errors++; $display("FAIL mrst_async_dout: got %h want %h", bus.dout, 8'h00); end
      checks++; if (bus.parity_done !== 1'b0 || bus.err !== 1'b0 || bus.low_pkt_valid !== 1'b0) begin
         errors++; $display("FAIL mrst_async_flags: got pd=%b err=%b lpv=%b want 0 0 0", bus.parity_done, bus.err, bus.low_pkt_valid);
      end
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0);
      checks++; if (bus.dout !== 8'h00 || bus.parity_done !== 1'b0 || bus.low_pkt_valid !== 1'b0 || bus.err !== 1'b0) begin
         errors++; $display("FAIL mrst_held: got dout=%h pd=%b lpv=%b err=%b want 00 0 0 0", bus.dout, bus.parity_done, bus.low_pkt_valid, bus.err);
      end
      reset = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_good_packet();
      test_bad_parity();
      test_full_payload();
      test_full_parity();
      test_invalid_addr();
      test_reset_mid_payload();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
